// File: rtl/uart_pkg.sv
// uart_pkg: receiver FSM states and UART frame constants shared by the receive path.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam int   DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
endpackage

// File: rtl/uart_receiver_if.sv
// uart_receiver_if: serial line plus RDR read handshake between the receiver and its consumer.
interface uart_receiver_if;
    logic       RxD;
    logic       rd;
    logic [7:0] dout;
    logic       RF;
    logic       FE;
    logic       OE;
    logic       PE;
    modport slave  (input RxD, rd, output dout, RF, FE, OE, PE);
    modport master (output RxD, rd, input dout, RF, FE, OE, PE);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider giving a one-clk tick every CLK_DIV cycles.
module uart_baud_tick #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic resetn,
    output logic tick
);
    localparam int CW = $clog2(CLK_DIV);
    logic [CW-1:0] r_cnt;
    assign tick = r_cnt == CW'(CLK_DIV - 1);
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_cnt <= '0;
        else         r_cnt <= tick ? '0 : r_cnt + CW'(1);
    end
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: oversampling UART receiver with RDR, RF flag and framing/overrun errors.
// Defining UART_RX_PARITY_EN adds an even-parity bit before the stop bit; otherwise PE reads 0.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_DIV = 16,
    parameter int OVS     = 16
) (
    input logic            clk,
    input logic            resetn,
    uart_receiver_if.slave bus
);
    localparam int SW = $clog2(OVS);
    localparam int BW = $clog2(DATA_BITS);
`ifdef UART_RX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = STOP;
`endif
    logic [1:0]           r_sync;
    state_t               r_state;
    logic [SW-1:0]        r_scnt;
    logic [BW-1:0]        r_bitcnt;
    logic [DATA_BITS-1:0] r_rsr;
    logic [DATA_BITS-1:0] r_dout;
    logic                 r_rf;
    logic                 r_fe;
    logic                 r_oe;
    logic                 w_tick;
    logic                 w_rxs;
    logic                 w_mid;
    logic                 w_end;
    logic                 w_load;
`ifdef UART_RX_PARITY_EN
    logic                 r_par;
    logic                 r_pe;
    assign bus.PE = r_pe;
`else
    assign bus.PE = 1'b0;
`endif
    uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .resetn(resetn),
        .tick  (w_tick)
    );
    assign w_rxs    = r_sync[1];
    assign w_mid    = r_scnt == SW'(OVS / 2 - 1);
    assign w_end    = r_scnt == SW'(OVS - 1);
    assign w_load   = !r_rf || bus.rd;
    assign bus.dout = r_dout;
    assign bus.RF   = r_rf;
    assign bus.FE   = r_fe;
    assign bus.OE   = r_oe;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync   <= 2'b11;
            r_state  <= IDLE;
            r_scnt   <= '0;
            r_bitcnt <= '0;
            r_rsr    <= '0;
            r_dout   <= '0;
            r_rf     <= 1'b0;
            r_fe     <= 1'b0;
            r_oe     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par    <= 1'b0;
            r_pe     <= 1'b0;
`endif
        end else begin
            r_sync <= {r_sync[0], bus.RxD};
            // a stop-bit transfer below overrides this acknowledge when both land together
            if (bus.rd) begin
                r_rf <= 1'b0;
                r_oe <= 1'b0;
            end
            if (w_tick) begin
                case (r_state)
                    IDLE: begin
                        if (w_rxs == START_BIT) begin
                            r_state <= START;
                            r_scnt  <= '0;
                        end
                    end
                    START: begin
                        if (w_mid) begin
                            r_state  <= (w_rxs == START_BIT) ? DATA : IDLE;
                            r_scnt   <= '0;
                            r_bitcnt <= '0;
                        end else r_scnt <= r_scnt + SW'(1);
                    end
                    DATA: begin
                        if (w_end) begin
                            r_rsr    <= {w_rxs, r_rsr[DATA_BITS-1:1]};
                            r_scnt   <= '0;
                            r_bitcnt <= r_bitcnt + BW'(1);
                            if (r_bitcnt == BW'(DATA_BITS - 1)) r_state <= AFTER_DATA;
                        end else r_scnt <= r_scnt + SW'(1);
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (w_end) begin
                            r_par   <= w_rxs;
                            r_scnt  <= '0;
                            r_state <= STOP;
                        end else r_scnt <= r_scnt + SW'(1);
                    end
`endif
                    STOP: begin
                        if (w_end) begin
                            r_state <= IDLE;
                            r_scnt  <= '0;
                            if (w_load) begin
                                r_dout <= r_rsr;
                                r_rf   <= 1'b1;
                                r_fe   <= w_rxs != STOP_BIT;
`ifdef UART_RX_PARITY_EN
                                r_pe   <= (^r_rsr) ^ r_par;
`endif
                            end else r_oe <= 1'b1;
                        end else r_scnt <= r_scnt + SW'(1);
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule
